// File: rtl/btle_rx_pdu_streamer.sv
// btle_rx_pdu_streamer
//
// Drain stage for the BTLE PHY receive path. When the decoder signals that a
// packet is complete, this block latches the packet length and CRC status,
// reads the PDU octet memory sequentially and presents the header and
// payload octets as a valid/ready byte stream. A 2-entry output FIFO with
// read prefetch sustains one octet per cycle while the sink keeps m_ready high.
//
// Optional feature: define BTLE_RX_DROP_CRC_FAIL_EN to discard packets whose
// CRC failed; each discarded packet is counted in drop_count. Without the
// macro every packet is streamed and drop_count is tied to zero.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-low reset
//   rx_decode_end            one-cycle strobe: packet decoded, memory final
//   rx_crc_ok                CRC result, valid with rx_decode_end
//   rx_payload_length        payload octet count, valid with rx_decode_end
//   rx_pdu_octet_mem_addr    PDU memory read address
//   rx_pdu_octet_mem_data    PDU memory read data, one cycle after address
//   m_data/m_valid/m_ready   output octet stream
//   m_last                   final octet of the packet
//   m_crc_ok                 latched CRC status of the streamed packet
//   busy                     a packet is being streamed
//   overrun                  one-cycle pulse: rx_decode_end arrived while busy
//   drop_count               saturating count of discarded packets

module btle_rx_pdu_streamer #(
  parameter int PDU_ADDR_BIT_WIDTH    = 6,
  parameter int PAYLOAD_LEN_BIT_WIDTH = 7,
  parameter int DROP_CNT_BIT_WIDTH    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx_decode_end,
  input  logic                             rx_crc_ok,
  input  logic [PAYLOAD_LEN_BIT_WIDTH-1:0] rx_payload_length,
  output logic [PDU_ADDR_BIT_WIDTH-1:0]    rx_pdu_octet_mem_addr,
  input  logic [7:0]                       rx_pdu_octet_mem_data,
  output logic [7:0]                       m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             m_last,
  output logic                             m_crc_ok,
  output logic                             busy,
  output logic                             overrun,
  output logic [DROP_CNT_BIT_WIDTH-1:0]    drop_count
);

  // Wide enough to hold both payload_length + 2 and the memory depth.
  localparam int CNT_W = ((PAYLOAD_LEN_BIT_WIDTH > PDU_ADDR_BIT_WIDTH) ?
                          PAYLOAD_LEN_BIT_WIDTH : PDU_ADDR_BIT_WIDTH) + 2;
  localparam logic [CNT_W-1:0] MEM_DEPTH = CNT_W'(1) << PDU_ADDR_BIT_WIDTH;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_t;

  state_t                        state_q;
  logic [CNT_W-1:0]              len_q;
  logic [CNT_W-1:0]              idx_q;
  logic                          crc_q;
  logic                          busy_q;
  logic                          overrun_q;
  logic [PDU_ADDR_BIT_WIDTH-1:0] addr_q;
  logic                          rd_pending_q;
  logic                          rd_last_q;
  logic [7:0]                    fifo_data_q [2];
  logic                          fifo_last_q [2];
  logic                          wr_ptr_q;
  logic                          rd_ptr_q;
  logic [1:0]                    fifo_cnt_q;

  logic [CNT_W-1:0] len_sum;
  logic [CNT_W-1:0] len_clamped;
  logic             pop;
  logic [1:0]       occ_net;
  logic             issue;
  logic             start_pkt;

  // Header is two octets; the whole packet cannot exceed the memory depth.
  assign len_sum     = CNT_W'(rx_payload_length) + CNT_W'(2);
  assign len_clamped = (len_sum > MEM_DEPTH) ? MEM_DEPTH : len_sum;

  assign m_valid = (fifo_cnt_q != 2'd0);
  assign m_data  = fifo_data_q[rd_ptr_q];
  assign m_last  = fifo_last_q[rd_ptr_q];
  assign pop     = m_valid & m_ready;

  // Occupancy is taken net of this cycle's pop, plus the read whose data is
  // on the memory bus now. A read issued here lands in the FIFO two edges
  // later, so keeping this sum below 2 guarantees a free slot while still
  // allowing one read per cycle under continuous ready.
  assign occ_net = fifo_cnt_q - {1'b0, pop} + {1'b0, rd_pending_q};
  assign issue   = (state_q == ST_STREAM) && (idx_q < len_q) && (occ_net < 2'd2);

  // The address is presented in the issuing cycle and held otherwise.
  assign rx_pdu_octet_mem_addr = issue ? idx_q[PDU_ADDR_BIT_WIDTH-1:0] : addr_q;

`ifdef BTLE_RX_DROP_CRC_FAIL_EN
  logic                          drop_pkt;
  logic [DROP_CNT_BIT_WIDTH-1:0] drop_q;

  assign start_pkt  = rx_decode_end & (state_q == ST_IDLE) & rx_crc_ok;
  assign drop_pkt   = rx_decode_end & (state_q == ST_IDLE) & ~rx_crc_ok;
  assign drop_count = drop_q;

  // A CRC-failed packet never enters the stream; only count it, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
    end else if (drop_pkt && (drop_q != '1)) begin
      drop_q <= drop_q + DROP_CNT_BIT_WIDTH'(1);
    end
  end
`else
  assign start_pkt  = rx_decode_end & (state_q == ST_IDLE);
  assign drop_count = '0;
`endif

  assign m_crc_ok = crc_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

  // Packet FSM, read issue and the 2-entry FIFO. A strobe while busy only
  // raises overrun; the packet in flight is never disturbed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      idx_q          <= '0;
      crc_q          <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      addr_q         <= '0;
      rd_pending_q   <= 1'b0;
      rd_last_q      <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      fifo_cnt_q     <= 2'd0;
    end else begin
      overrun_q    <= rx_decode_end & busy_q;
      addr_q       <= rx_pdu_octet_mem_addr;
      rd_pending_q <= issue;

      if (issue) begin
        idx_q     <= idx_q + CNT_W'(1);
        rd_last_q <= (idx_q == (len_q - CNT_W'(1)));
      end

      if (rd_pending_q) begin
        fifo_data_q[wr_ptr_q] <= rx_pdu_octet_mem_data;
        fifo_last_q[wr_ptr_q] <= rd_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end

      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end

      fifo_cnt_q <= fifo_cnt_q + {1'b0, rd_pending_q} - {1'b0, pop};

      case (state_q)
        ST_IDLE: begin
          if (start_pkt) begin
            len_q   <= len_clamped;
            crc_q   <= rx_crc_ok;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (pop && fifo_last_q[rd_ptr_q]) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
